axi_rd_arbiter: RTL and testbench



---
 rtl/ddf_axi_pkg.sv | 21 ++
 rtl/axi_rd_arbiter_rr_arb2.sv | 29 ++
 rtl/axi_rd_arbiter.sv | 142 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddf_axi_pkg.sv
// Shared AXI constants and request types for the display-data-fetch read path.
package ddf_axi_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_64    = 3'd3;
  localparam logic [3:0] AXI_CACHE_DFLT = 4'b0011;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [5:0]  id;
  } ar_req_t;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner so a tie
// goes to the other requester.
module rr_arb2 (
  input  logic       vin_clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni)                r_last <= 1'b1;
    else if (advance && |gnt)   r_last <= gnt[1];
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 read port between two requesters: round-robin AR issue with
// per-requester outstanding limits, ID tagging and zero-latency R routing.
module axi_rd_arbiter
  import ddf_axi_pkg::*;
#(
  parameter logic [5:0] ID_BASE = 6'h10,
  parameter int         MAX_OUT = 4
) (
  input  logic        vin_clk_i,
  input  logic        rst_ni,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  input  logic [31:0] s0_araddr,
  input  logic [3:0]  s0_arlen,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  output logic        s0_rlast,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  input  logic [31:0] s1_araddr,
  input  logic [3:0]  s1_arlen,
  output logic        s1_rvalid,
  input  logic        s1_rready,
  output logic        s1_rlast,
  output logic [63:0] r_data_o,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [3:0]  m_axi_arlen,
  output logic [5:0]  m_axi_arid,
  output logic [1:0]  m_axi_arburst,
  output logic [2:0]  m_axi_arsize,
  output logic [3:0]  m_axi_arcache,
  output logic [1:0]  m_axi_arlock,
  output logic [2:0]  m_axi_arprot,
  output logic [3:0]  m_axi_arqos,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [63:0] m_axi_rdata,
  input  logic        m_axi_rlast,
  input  logic [5:0]  m_axi_rid,
  input  logic [1:0]  m_axi_rresp,
  output logic        err_o
);

  localparam logic [3:0] LIM = 4'(MAX_OUT);

  ar_state_e              r_state, w_state_nxt;
  ar_req_t                r_ar;
  ar_req_t [NUM_REQ-1:0]  w_sreq;
  logic [NUM_REQ-1:0]     w_arvalid, w_elig, w_req, w_gnt, w_dec, w_zlast;
  logic [NUM_REQ-1:0][3:0] r_cnt;
  logic                   w_idle, w_own, w_sel, w_hs, r_err;

  assign w_arvalid = {s1_arvalid, s0_arvalid};
  assign w_sreq[0] = '{addr: s0_araddr, len: s0_arlen, id: {ID_BASE[5:1], 1'b0}};
  assign w_sreq[1] = '{addr: s1_araddr, len: s1_arlen, id: {ID_BASE[5:1], 1'b1}};

  // Grants are only offered in IDLE and never while reset is asserted.
  assign w_idle = (r_state == AR_IDLE) && rst_ni;
  assign w_req  = w_elig & {NUM_REQ{w_idle}};

  rr_arb2 u_rr (
    .vin_clk_i (vin_clk_i),
    .rst_ni    (rst_ni),
    .req       (w_req),
    .advance   (w_idle),
    .gnt       (w_gnt)
  );

  assign s0_arready = w_gnt[0];
  assign s1_arready = w_gnt[1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AR_IDLE:  if (|w_gnt)        w_state_nxt = AR_ISSUE;
      AR_ISSUE: if (m_axi_arready) w_state_nxt = AR_IDLE;
      default:                     w_state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= AR_IDLE;
      r_ar    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (|w_gnt) r_ar <= w_gnt[1] ? w_sreq[1] : w_sreq[0];
    end
  end

  assign m_axi_arvalid = (r_state == AR_ISSUE);
  assign m_axi_araddr  = r_ar.addr;
  assign m_axi_arlen   = r_ar.len;
  assign m_axi_arid    = r_ar.id;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arsize  = AXI_SIZE_64;
  assign m_axi_arcache = AXI_CACHE_DFLT;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  // Foreign IDs are swallowed so they can never stall the shared port.
  assign w_own        = (m_axi_rid[5:1] == ID_BASE[5:1]);
  assign w_sel        = m_axi_rid[0];
  assign m_axi_rready = !w_own || (w_sel ? s1_rready : s0_rready);
  assign w_hs         = m_axi_rvalid && m_axi_rready;

  assign s0_rvalid = m_axi_rvalid && w_own && !w_sel;
  assign s1_rvalid = m_axi_rvalid && w_own &&  w_sel;
  assign s0_rlast  = m_axi_rlast;
  assign s1_rlast  = m_axi_rlast;
  assign r_data_o  = m_axi_rdata;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    logic w_rl;
    assign w_elig[k]  = w_arvalid[k] && (r_cnt[k] < LIM);
    assign w_rl       = w_hs && w_own && m_axi_rlast && (w_sel == 1'(k));
    assign w_dec[k]   = w_rl && (r_cnt[k] != 4'd0);
    assign w_zlast[k] = w_rl && (r_cnt[k] == 4'd0);

    always_ff @(posedge vin_clk_i or negedge rst_ni) begin
      if (!rst_ni) r_cnt[k] <= 4'd0;
      else begin
        case ({w_gnt[k], w_dec[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + 4'd1;
          2'b01:   r_cnt[k] <= r_cnt[k] - 4'd1;
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err <= 1'b0;
    else if (w_hs && (!w_own || (m_axi_rresp != 2'b00) || (|w_zlast))) r_err <= 1'b1;
  end

  assign err_o = r_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with a transaction-level reference model.
module tb_axi_rd_arbiter;

  localparam logic [5:0] IDB  = 6'h20;
  localparam int         MAXO = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [31:0] s0_araddr, s1_araddr, m_axi_araddr;
  logic [3:0]  s0_arlen, s1_arlen, m_axi_arlen, m_axi_arcache, m_axi_arqos;
  logic [63:0] r_data_o, m_axi_rdata;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast, err_o;
  logic [5:0] m_axi_arid, m_axi_rid;
  logic [1:0] m_axi_arburst, m_axi_arlock, m_axi_rresp;
  logic [2:0] m_axi_arsize, m_axi_arprot;

  axi_rd_arbiter #(.ID_BASE(IDB), .MAX_OUT(MAXO)) dut (
    .vin_clk_i(clk), .rst_ni(rst_ni),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rlast(s1_rlast),
    .r_data_o(r_data_o),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid), .m_axi_arburst(m_axi_arburst),
    .m_axi_arsize(m_axi_arsize), .m_axi_arcache(m_axi_arcache), .m_axi_arlock(m_axi_arlock),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
    .err_o(err_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: one pending AR slot, last winner, bursts in flight.
  bit          m_iss = 1'b0;
  logic [31:0] m_addr = '0;
  logic [3:0]  m_len = '0;
  logic [5:0]  m_id = '0;
  int          m_last = 1;
  int          m_cnt[2] = '{0, 0};
  bit          m_err = 1'b0;

  logic [5:0]  ar_ids[$];
  logic [31:0] ar_addrs[$];

  function automatic int pick();
    bit e0, e1;
    e0 = s0_arvalid && (m_cnt[0] < MAXO);
    e1 = s1_arvalid && (m_cnt[1] < MAXO);
    if (!rst_ni || m_iss) return -1;
    if (e0 && e1) return (m_last == 1) ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic bit own();
    return (m_axi_rid >> 1) == (IDB >> 1);
  endfunction

  function automatic bit exp_rready();
    if (!own()) return 1'b1;
    return m_axi_rid[0] ? s1_rready : s0_rready;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    int p, k;
    int inc[2];
    int dec[2];
    if (!rst_ni) begin
      m_iss = 1'b0; m_addr = '0; m_len = '0; m_id = '0;
      m_last = 1; m_cnt = '{0, 0}; m_err = 1'b0;
    end else begin
      inc = '{0, 0}; dec = '{0, 0};
      p = pick();
      if (m_iss) begin
        if (m_axi_arready) m_iss = 1'b0;
      end else if (p >= 0) begin
        m_iss  = 1'b1;
        m_last = p;
        m_addr = (p == 1) ? s1_araddr : s0_araddr;
        m_len  = (p == 1) ? s1_arlen : s0_arlen;
        m_id   = {IDB[5:1], 1'(p)};
        inc[p] = 1;
      end
      if (m_axi_rvalid && exp_rready()) begin
        if (!own()) m_err = 1'b1;
        else begin
          k = int'(m_axi_rid[0]);
          if (m_axi_rresp != 2'b00) m_err = 1'b1;
          if (m_axi_rlast) begin
            if (m_cnt[k] == 0) m_err = 1'b1;
            else dec[k] = 1;
          end
        end
      end
      for (int i = 0; i < 2; i++) m_cnt[i] = m_cnt[i] + inc[i] - dec[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon();
    forever begin : mb
      int p;
      @(negedge clk);
      p = pick();
      chk("s0_arready", s0_arready, p == 0);
      chk("s1_arready", s1_arready, p == 1);
      chk("m_arvalid", m_axi_arvalid, m_iss);
      chk("m_araddr", m_axi_araddr, m_addr);
      chk("m_arlen", m_axi_arlen, m_len);
      chk("m_arid", m_axi_arid, m_id);
      chk("s0_rvalid", s0_rvalid, m_axi_rvalid && own() && !m_axi_rid[0]);
      chk("s1_rvalid", s1_rvalid, m_axi_rvalid && own() && m_axi_rid[0]);
      chk("m_rready", m_axi_rready, exp_rready());
      chk("r_data", r_data_o, m_axi_rdata);
      chk("rlast", {s1_rlast, s0_rlast}, {m_axi_rlast, m_axi_rlast});
      chk("err", err_o, m_err);
      chk("ar_const", {m_axi_arburst, m_axi_arsize, m_axi_arcache, m_axi_arlock, m_axi_arprot, m_axi_arqos},
          {2'b01, 3'd3, 4'b0011, 2'b00, 3'b000, 4'b0000});
      if (rst_ni && m_axi_arvalid && m_axi_arready) begin
        ar_ids.push_back(m_axi_arid);
        ar_addrs.push_back(m_axi_araddr);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    s0_arvalid = 0; s1_arvalid = 0; s0_rready = 0; s1_rready = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rid = '0;
    m_axi_rresp = '0; m_axi_rdata = '0;
  endtask

  task automatic do_reset();
    quiet();
    rst_ni = 0;
    repeat (3) tick();
    rst_ni = 1;
    ar_ids.delete();
    ar_addrs.delete();
  endtask

  logic [5:0] exp1[4] = '{6'h20, 6'h21, 6'h20, 6'h21};

  initial begin
    s0_araddr = 32'h2100_0000; s1_araddr = 32'h2180_0000;
    s0_arlen = 4'd15; s1_arlen = 4'd15;
    quiet();
    fork mon(); join_none
    do_reset();
    @(negedge clk);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_arid", m_axi_arid, 0);
    chk("rst_err", err_o, 0);

    // 1: both hold arvalid, ids alternate starting with requester 0
    s0_arvalid = 1; s1_arvalid = 1; m_axi_arready = 1;
    repeat (8) tick();
    s0_arvalid = 0; s1_arvalid = 0;
    chk("t1_count", ar_ids.size(), 4);
    for (int i = 0; i < 4 && i < ar_ids.size(); i++) chk("t1_id", ar_ids[i], exp1[i]);
    if (ar_addrs.size() > 1) begin
      chk("t1_addr0", ar_addrs[0], 32'h2100_0000);
      chk("t1_addr1", ar_addrs[1], 32'h2180_0000);
    end

    // 2: outstanding limit, then one completed burst frees a slot
    do_reset();
    s0_arvalid = 1; m_axi_arready = 1;
    repeat (20) tick();
    chk("t2_limit", ar_ids.size(), 4);
    chk("t2_arready", s0_arready, 0);
    s0_rready = 1;
    for (int i = 0; i < 16; i++) begin
      m_axi_rvalid = 1; m_axi_rid = 6'h20; m_axi_rlast = (i == 15);
      m_axi_rdata = 64'hbeef_0000_0000_0000 | 64'(i);
      tick();
    end
    m_axi_rvalid = 0; m_axi_rlast = 0;
    repeat (4) tick();
    chk("t2_fifth", ar_ids.size(), 5);
    s0_arvalid = 0;

    // 3: backpressure from s1 reaches the master port
    do_reset();
    m_axi_rvalid = 1; m_axi_rid = 6'h21; m_axi_rdata = 64'h1234_5678_9abc_def0;
    s0_rready = 1; s1_rready = 0;
    tick();
    chk("t3_rready_lo", m_axi_rready, 0);
    chk("t3_s0_rvalid", s0_rvalid, 0);
    chk("t3_s1_rvalid", s1_rvalid, 1);
    s1_rready = 1;
    #1;
    chk("t3_rready_hi", m_axi_rready, 1);
    tick();
    m_axi_rvalid = 0;
    tick();
    chk("t3_err", err_o, 0);

    // 4: foreign id is swallowed and flagged
    do_reset();
    m_axi_rvalid = 1; m_axi_rid = 6'h05; m_axi_rlast = 1;
    #1;
    chk("t4_rready", m_axi_rready, 1);
    chk("t4_rvalid", {s1_rvalid, s0_rvalid}, 2'b00);
    chk("t4_err_pre", err_o, 0);
    tick();
    m_axi_rvalid = 0; m_axi_rlast = 0;
    chk("t4_err", err_o, 1);
    s0_arvalid = 1; m_axi_arready = 1;
    repeat (12) tick();
    s0_arvalid = 0;
    chk("t4_cnt_unchanged", ar_ids.size(), 4);

    // 5: error response still delivered
    do_reset();
    m_axi_rvalid = 1; m_axi_rid = 6'h20; m_axi_rresp = 2'b10; s0_rready = 1;
    #1;
    chk("t5_s0_rvalid", s0_rvalid, 1);
    chk("t5_err_pre", err_o, 0);
    tick();
    m_axi_rvalid = 0; m_axi_rresp = 0;
    chk("t5_err", err_o, 1);

    // 6: reset during ISSUE drops arvalid immediately; first tie goes to s0
    do_reset();
    s0_arvalid = 1; s1_arvalid = 1; m_axi_arready = 0;
    tick();
    chk("t6_issue", m_axi_arvalid, 1);
    chk("t6_issue_id", m_axi_arid, 6'h20);
    rst_ni = 0;
    #1;
    chk("t6_rst_arvalid", m_axi_arvalid, 0);
    chk("t6_rst_arid", m_axi_arid, 0);
    repeat (2) tick();
    rst_ni = 1;
    ar_ids.delete();
    m_axi_arready = 1;
    repeat (2) tick();
    chk("t6_count", ar_ids.size(), 1);
    if (ar_ids.size() > 0) chk("t6_first", ar_ids[0], 6'h20);
    quiet();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
